hcms_display_rx: RTL and testbench
==================================

HCMS_DISPLAY_RX -- requirements
Module: hcms_display_rx

Interface
REQ-001 SHALL have parameter DOT_BYTES, default 20, meaning the number of dot-column bytes in one display frame (range 2-32).
REQ-002 SHALL have port CLK_i, input, 1 bit: the single system clock; all logic is on its rising edge; frequency at least 4x the SER_CLK frequency.
REQ-003 SHALL have port RST_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port SER_DATA_i, input, 1 bit: serial data; asynchronous to CLK_i.
REQ-005 SHALL have port SER_CLK_i, input, 1 bit: serial clock, idles high; data is valid on its rising edge.
REQ-006 SHALL have port REG_SEL_i, input, 1 bit: register select; 1 = control register, 0 = dot register.
REQ-007 SHALL have port nCE_i, input, 1 bit: active-low chip enable that frames a load.
REQ-008 SHALL have port nRESET_i, input, 1 bit: active-low display reset.
REQ-009 SHALL have port DATA_o, output, 8 bits: the last completed dot byte.
REQ-010 SHALL have port DATA_VALID_o, output, 1 bit: one-cycle pulse when DATA_o/COL_o update.
REQ-011 SHALL have port COL_o, output, 5 bits: column index of DATA_o, 0..DOT_BYTES-1.
REQ-012 SHALL have port CTRL0_o, output, 7 bits: control word 0 payload (bits 6:0).
REQ-013 SHALL have port CTRL1_o, output, 2 bits: control word 1 payload (bits 1:0).
REQ-014 SHALL have port CTRL_VALID_o, output, 1 bit: one-cycle pulse on any control-word update.
REQ-015 SHALL have port FRAME_ERR_o, output, 1 bit: one-cycle pulse on a malformed load.
REQ-016 SHALL have port BUSY_o, output, 1 bit: high while the synchronised nCE is low.

Function
REQ-017 SHALL pass each serial input through a 2-FF synchroniser; all later rules refer to the synchronised signals (_s).
REQ-018 SHALL detect a SER_CLK rise as SER_CLK_s = 1 in the current cycle and 0 in the previous cycle; the nCE fall and rise edges SHALL be detected the same way.
REQ-019 SHALL implement the FSM IDLE -> ACTIVE on the nCE_s fall; ACTIVE -> EVAL on the nCE_s rise; EVAL -> IDLE unconditionally after 1 cycle.
REQ-020 SHALL, on the nCE_s fall, latch REG_SEL_s for the frame, clear the bit counter (3-bit), the shift register, and the column counter; a change of REG_SEL mid-frame SHALL be ignored.
REQ-021 SHALL, in ACTIVE on each SER_CLK_s rise, shift SER_DATA_s in MSB-first and increment the bit counter (mod 8).
REQ-022 SHALL, for a dot frame on the 8th bit, load DATA_o in the next cycle with the assembled byte, set COL_o to the column counter, pulse DATA_VALID_o, and increment the column counter, wrapping from DOT_BYTES-1 to 0.
REQ-023 SHALL, for a control frame, track whether exactly 8 bits were received (a 9th bit marks the frame overlength); no output SHALL change before EVAL.
REQ-024 SHALL, in EVAL of a control frame with exactly 8 bits: if bit 7 = 0, set CTRL0_o to bits 6:0; if bit 7 = 1, set CTRL1_o to bits 1:0 and leave CTRL0_o unchanged; in both cases pulse CTRL_VALID_o.
REQ-025 SHALL, in EVAL with a partial byte (bit counter != 0) or a control bit count != 8, pulse FRAME_ERR_o and discard the partial data; bytes already emitted SHALL stand.
REQ-026 SHALL, when a SER_CLK_s rise and the nCE_s rise occur in the same cycle, discard that bit.
REQ-027 SHALL ignore SER_CLK_s rises in IDLE and EVAL.
REQ-028 SHALL, while nRESET_s = 0: force IDLE, abort any frame without a pulse, clear CTRL0_o, CTRL1_o, and the counters, and ignore nCE; BUSY_o SHALL be 0.
REQ-029 SHALL drive all outputs from registers; pulses SHALL last exactly 1 CLK_i cycle.

Reset
REQ-030 SHALL, on RST_i, clear DATA_o, COL_o, CTRL0_o, CTRL1_o, all pulses, BUSY_o, and the counters to 0, and set the FSM to IDLE.
REQ-031 SHALL, on RST_i, preset the synchroniser stages to idle levels: SER_CLK = 1, nCE = 1, nRESET = 1, others 0.
REQ-032 SHALL let RST_i take precedence over all other inputs in the same cycle.
REQ-033 SHALL, on RST_i mid-frame, abort the frame with no pulse.

Verification
REQ-034 SHALL cover: control load 8'b10000001 -> CTRL1_o = 2'b01, CTRL0_o unchanged, exactly one CTRL_VALID_o pulse in EVAL.
REQ-035 SHALL cover: control load 8'b01111001 -> CTRL0_o = 7'h79, one CTRL_VALID_o pulse, FRAME_ERR_o stays 0.
REQ-036 SHALL cover: dot frame with bytes 0x00, 0x01, 0x02 -> three DATA_VALID_o pulses with DATA_o/COL_o = 0x00/0, 0x01/1, 0x02/2.
REQ-037 SHALL cover: dot frame with 21 bytes, DOT_BYTES = 20 -> 20th byte has COL_o = 19 and 21st byte has COL_o = 0.
REQ-038 SHALL cover: nCE rise after 5 bits (dot frame) and after 9 bits (control frame) -> one FRAME_ERR_o pulse each, with no DATA_VALID_o and no CTRL_VALID_o.
REQ-039 SHALL cover: nRESET_i low during the 4th bit of a load after CTRL0_o = 7'h79 -> CTRL0_o = 0, BUSY_o = 0, no pulses; the next valid load decodes normally.

Source files
------------

// File: rtl/hcms_display_rx_if.sv
// Serial load bus of an HCMS-style dot-matrix display: the host drives it,
// the receiver samples it asynchronously to its own clock.
interface hcms_display_rx_if;
  logic SER_DATA_i;
  logic SER_CLK_i;
  logic REG_SEL_i;
  logic nCE_i;
  logic nRESET_i;

  modport master (
    output SER_DATA_i, SER_CLK_i, REG_SEL_i, nCE_i, nRESET_i
  );

  modport slave (
    input SER_DATA_i, SER_CLK_i, REG_SEL_i, nCE_i, nRESET_i
  );
endinterface

// File: rtl/hcms_display_rx.sv
// Receiver that decodes HCMS-style serial display loads into dot-column bytes
// and control words, oversampling the serial bus with the system clock.
module hcms_display_rx #(
  parameter int DOT_BYTES = 20
) (
  input  logic                 CLK_i,
  input  logic                 RST_i,
  hcms_display_rx_if.slave     ser_if,
  output logic [7:0]           DATA_o,
  output logic                 DATA_VALID_o,
  output logic [4:0]           COL_o,
  output logic [6:0]           CTRL0_o,
  output logic [1:0]           CTRL1_o,
  output logic                 CTRL_VALID_o,
  output logic                 FRAME_ERR_o,
  output logic                 BUSY_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_EVAL   = 2'd2
  } state_e;

  localparam logic [4:0] COL_LAST = 5'(DOT_BYTES - 1);

  logic [1:0] data_sync_q, sclk_sync_q, rsel_sync_q, nce_sync_q, nrst_sync_q;
  logic       sclk_prev_q, nce_prev_q;

  // NOTE: synchroniser stages preset to the bus idle levels so that leaving
  // reset can never look like a serial clock edge or a chip-enable fall.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      data_sync_q <= 2'b00;
      sclk_sync_q <= 2'b11;
      rsel_sync_q <= 2'b00;
      nce_sync_q  <= 2'b11;
      nrst_sync_q <= 2'b11;
      sclk_prev_q <= 1'b1;
      nce_prev_q  <= 1'b1;
    end else begin
      data_sync_q <= {data_sync_q[0], ser_if.SER_DATA_i};
      sclk_sync_q <= {sclk_sync_q[0], ser_if.SER_CLK_i};
      rsel_sync_q <= {rsel_sync_q[0], ser_if.REG_SEL_i};
      nce_sync_q  <= {nce_sync_q[0],  ser_if.nCE_i};
      nrst_sync_q <= {nrst_sync_q[0], ser_if.nRESET_i};
      sclk_prev_q <= sclk_sync_q[1];
      nce_prev_q  <= nce_sync_q[1];
    end
  end

  logic ser_data_s, sclk_s, rsel_s, nce_s, nrst_s;
  logic sclk_rise, nce_fall, nce_rise;

  assign ser_data_s = data_sync_q[1];
  assign sclk_s     = sclk_sync_q[1];
  assign rsel_s     = rsel_sync_q[1];
  assign nce_s      = nce_sync_q[1];
  assign nrst_s     = nrst_sync_q[1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign nce_fall   = ~nce_s & nce_prev_q;
  assign nce_rise   = nce_s & ~nce_prev_q;

  state_e     state_q;
  logic       is_ctrl_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic [4:0] col_cnt_q;
  logic       byte_done_q;
  logic       over_q;
  logic [7:0] data_q;
  logic [4:0] col_q;
  logic [6:0] ctrl0_q;
  logic [1:0] ctrl1_q;
  logic       data_valid_q, ctrl_valid_q, frame_err_q, busy_q;

  assign shift_d = {shift_q[6:0], ser_data_s};

  // NOTE: every state element below uses non-blocking assignment so all
  // registers update together from the values sampled at the same edge.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q      <= ST_IDLE;
      is_ctrl_q    <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      col_cnt_q    <= 5'd0;
      byte_done_q  <= 1'b0;
      over_q       <= 1'b0;
      data_q       <= 8'h00;
      col_q        <= 5'd0;
      ctrl0_q      <= 7'h00;
      ctrl1_q      <= 2'b00;
      data_valid_q <= 1'b0;
      ctrl_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      ctrl_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= ~nce_s & nrst_s;

      if (!nrst_s) begin
        // Display reset aborts silently and holds the receiver idle.
        state_q     <= ST_IDLE;
        bit_cnt_q   <= 3'd0;
        shift_q     <= 8'h00;
        col_cnt_q   <= 5'd0;
        byte_done_q <= 1'b0;
        over_q      <= 1'b0;
        ctrl0_q     <= 7'h00;
        ctrl1_q     <= 2'b00;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (nce_fall) begin
              state_q     <= ST_ACTIVE;
              is_ctrl_q   <= rsel_s;
              bit_cnt_q   <= 3'd0;
              shift_q     <= 8'h00;
              col_cnt_q   <= 5'd0;
              byte_done_q <= 1'b0;
              over_q      <= 1'b0;
            end
          end

          ST_ACTIVE: begin
            if (nce_rise) begin
              // A bit clocked in the same cycle as the frame end is dropped.
              state_q <= ST_EVAL;
            end else if (sclk_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (is_ctrl_q) begin
                if (byte_done_q) over_q <= 1'b1;
                if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
              end else if (bit_cnt_q == 3'd7) begin
                data_q       <= shift_d;
                col_q        <= col_cnt_q;
                data_valid_q <= 1'b1;
                col_cnt_q    <= (col_cnt_q == COL_LAST) ? 5'd0 : col_cnt_q + 5'd1;
              end
            end
          end

          ST_EVAL: begin
            state_q <= ST_IDLE;
            if (is_ctrl_q) begin
              if (byte_done_q && !over_q && bit_cnt_q == 3'd0) begin
                if (shift_q[7]) ctrl1_q <= shift_q[1:0];
                else            ctrl0_q <= shift_q[6:0];
                ctrl_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else if (bit_cnt_q != 3'd0) begin
              frame_err_q <= 1'b1;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign DATA_o       = data_q;
  assign DATA_VALID_o = data_valid_q;
  assign COL_o        = col_q;
  assign CTRL0_o      = ctrl0_q;
  assign CTRL1_o      = ctrl1_q;
  assign CTRL_VALID_o = ctrl_valid_q;
  assign FRAME_ERR_o  = frame_err_q;
  assign BUSY_o       = busy_q;

endmodule

// File: tb/tb_hcms_display_rx.sv
// Self-checking bench for hcms_display_rx: directed corner loads plus random
// frames, each compared against a frame-level reference model.
module tb_hcms_display_rx;

  localparam int DOT_BYTES = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] DATA_o;
  logic       DATA_VALID_o;
  logic [4:0] COL_o;
  logic [6:0] CTRL0_o;
  logic [1:0] CTRL1_o;
  logic       CTRL_VALID_o;
  logic       FRAME_ERR_o;
  logic       BUSY_o;

  hcms_display_rx_if ser_if ();

  hcms_display_rx #(.DOT_BYTES(DOT_BYTES)) dut (
    .CLK_i        (clk),
    .RST_i        (rst),
    .ser_if       (ser_if.slave),
    .DATA_o       (DATA_o),
    .DATA_VALID_o (DATA_VALID_o),
    .COL_o        (COL_o),
    .CTRL0_o      (CTRL0_o),
    .CTRL1_o      (CTRL1_o),
    .CTRL_VALID_o (CTRL_VALID_o),
    .FRAME_ERR_o  (FRAME_ERR_o),
    .BUSY_o       (BUSY_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: cumulative pulse log, sampled away from the active edge.
  logic [12:0] dv_log[$];
  int ctrl_pulses = 0;
  int err_pulses  = 0;
  int long_pulses = 0;
  logic dv_prev = 1'b0, cv_prev = 1'b0, fe_prev = 1'b0;

  always @(negedge clk) begin
    if (DATA_VALID_o) dv_log.push_back({DATA_o, COL_o});
    if (CTRL_VALID_o) ctrl_pulses++;
    if (FRAME_ERR_o)  err_pulses++;
    if ((DATA_VALID_o && dv_prev) || (CTRL_VALID_o && cv_prev) || (FRAME_ERR_o && fe_prev))
      long_pulses++;
    dv_prev = DATA_VALID_o;
    cv_prev = CTRL_VALID_o;
    fe_prev = FRAME_ERR_o;
  end

  // Reference model state
  logic [6:0]  exp_ctrl0 = 7'h00;
  logic [1:0]  exp_ctrl1 = 2'b00;
  logic        frame_bits[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) frame_bits.push_back(b[j]);
  endtask

  task automatic send_bit(input logic b);
    ser_if.SER_CLK_i  = 1'b0;
    ser_if.SER_DATA_i = b;
    tick(4);
    ser_if.SER_CLK_i  = 1'b1;
    tick(4);
  endtask

  // Drives one load made of frame_bits; coincide=1 raises nCE together with
  // the final serial clock rise, so the model drops that bit.
  task automatic run_frame(input string tag, input logic rs, input logic coincide);
    int          n_sent;
    int          n_eff;
    int          dv_base, cv_base, fe_base;
    int          exp_cv, exp_fe;
    logic [12:0] exp_dv[$];
    logic [7:0]  b;

    n_sent = frame_bits.size();
    n_eff  = coincide ? n_sent - 1 : n_sent;
    exp_cv = 0;
    exp_fe = 0;
    if (!rs) begin
      for (int k = 0; k < n_eff / 8; k++) begin
        b = 8'h00;
        for (int j = 0; j < 8; j++) b = {b[6:0], frame_bits[8*k + j]};
        exp_dv.push_back({b, 5'(k % DOT_BYTES)});
      end
      if (n_eff % 8 != 0) exp_fe = 1;
    end else if (n_eff == 8) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++) b = {b[6:0], frame_bits[j]};
      if (b[7]) exp_ctrl1 = b[1:0];
      else      exp_ctrl0 = b[6:0];
      exp_cv = 1;
    end else begin
      exp_fe = 1;
    end

    dv_base = dv_log.size();
    cv_base = ctrl_pulses;
    fe_base = err_pulses;

    ser_if.REG_SEL_i = rs;
    tick(3);
    ser_if.nCE_i = 1'b0;
    tick(4);
    ser_if.REG_SEL_i = ~rs;
    check({tag, "_busy"}, 32'(BUSY_o), 32'd1);
    for (int i = 0; i < n_sent; i++) begin
      if (coincide && i == n_sent - 1) begin
        ser_if.SER_CLK_i  = 1'b0;
        ser_if.SER_DATA_i = frame_bits[i];
        tick(4);
        ser_if.SER_CLK_i = 1'b1;
        ser_if.nCE_i     = 1'b1;
      end else begin
        send_bit(frame_bits[i]);
      end
    end
    ser_if.nCE_i = 1'b1;
    tick(10);

    check({tag, "_idle"}, 32'(BUSY_o), 32'd0);
    check({tag, "_dv_count"}, 32'(dv_log.size() - dv_base), 32'(exp_dv.size()));
    for (int k = 0; k < exp_dv.size() && dv_base + k < dv_log.size(); k++) begin
      check($sformatf("%s_byte%0d", tag, k), 32'(dv_log[dv_base + k][12:5]), 32'(exp_dv[k][12:5]));
      check($sformatf("%s_col%0d", tag, k),  32'(dv_log[dv_base + k][4:0]),  32'(exp_dv[k][4:0]));
    end
    check({tag, "_ctrl_valid"}, 32'(ctrl_pulses - cv_base), 32'(exp_cv));
    check({tag, "_frame_err"},  32'(err_pulses - fe_base),  32'(exp_fe));
    check({tag, "_ctrl0"}, 32'(CTRL0_o), 32'(exp_ctrl0));
    check({tag, "_ctrl1"}, 32'(CTRL1_o), 32'(exp_ctrl1));
    frame_bits.delete();
    ser_if.REG_SEL_i = 1'b0;
    tick(2);
  endtask

  initial begin
    int dv_base, cv_base, fe_base, n;
    logic rs, coincide;

    rst               = 1'b1;
    ser_if.SER_DATA_i = 1'b0;
    ser_if.SER_CLK_i  = 1'b1;
    ser_if.REG_SEL_i  = 1'b0;
    ser_if.nCE_i      = 1'b1;
    ser_if.nRESET_i   = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(4);
    check("rst_data",  32'(DATA_o),  32'd0);
    check("rst_col",   32'(COL_o),   32'd0);
    check("rst_ctrl0", 32'(CTRL0_o), 32'd0);
    check("rst_ctrl1", 32'(CTRL1_o), 32'd0);
    check("rst_busy",  32'(BUSY_o),  32'd0);
    check("rst_pulses", 32'(ctrl_pulses + err_pulses + dv_log.size()), 32'd0);

    // RST in the middle of a control load: aborted with no pulse.
    push_byte(8'h55);
    run_frame("pre_rst", 1'b1, 1'b0);
    dv_base = dv_log.size(); cv_base = ctrl_pulses; fe_base = err_pulses;
    ser_if.REG_SEL_i = 1'b1;
    tick(3);
    ser_if.nCE_i = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rst = 1'b1;
    tick(2);
    ser_if.nCE_i = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(10);
    exp_ctrl0 = 7'h00;
    exp_ctrl1 = 2'b00;
    check("midrst_pulses", 32'(ctrl_pulses - cv_base + err_pulses - fe_base + dv_log.size() - dv_base), 32'd0);
    check("midrst_ctrl0", 32'(CTRL0_o), 32'(exp_ctrl0));
    ser_if.REG_SEL_i = 1'b0;

    push_byte(8'b0111_1001);
    run_frame("ctrl0_79", 1'b1, 1'b0);
    push_byte(8'b1000_0001);
    run_frame("ctrl1_01", 1'b1, 1'b0);

    push_byte(8'h00); push_byte(8'h01); push_byte(8'h02);
    run_frame("dot3", 1'b0, 1'b0);

    for (int k = 0; k < 21; k++) push_byte(8'($urandom_range(0, 255)));
    run_frame("dot21_wrap", 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
    run_frame("dot_short5", 1'b0, 1'b0);
    push_byte(8'h12); frame_bits.push_back(1'b1);
    run_frame("ctrl_long9", 1'b1, 1'b0);

    // Ninth bit coincides with the nCE rise and must be discarded.
    push_byte(8'h33); frame_bits.push_back(1'b1);
    run_frame("ctrl_coincide", 1'b1, 1'b1);

    // Display reset during the 4th bit of a load.
    push_byte(8'b0111_1001);
    run_frame("ctrl0_79b", 1'b1, 1'b0);
    dv_base = dv_log.size(); cv_base = ctrl_pulses; fe_base = err_pulses;
    ser_if.REG_SEL_i = 1'b1;
    tick(3);
    ser_if.nCE_i = 1'b0;
    tick(4);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    ser_if.SER_CLK_i  = 1'b0;
    ser_if.SER_DATA_i = 1'b0;
    tick(2);
    ser_if.nRESET_i = 1'b0;
    tick(2);
    ser_if.SER_CLK_i = 1'b1;
    tick(4);
    exp_ctrl0 = 7'h00;
    exp_ctrl1 = 2'b00;
    check("nreset_busy",  32'(BUSY_o),  32'd0);
    check("nreset_ctrl0", 32'(CTRL0_o), 32'(exp_ctrl0));
    check("nreset_ctrl1", 32'(CTRL1_o), 32'(exp_ctrl1));
    ser_if.nCE_i = 1'b1;
    tick(4);
    ser_if.nRESET_i = 1'b1;
    tick(8);
    check("nreset_pulses", 32'(ctrl_pulses - cv_base + err_pulses - fe_base + dv_log.size() - dv_base), 32'd0);
    ser_if.REG_SEL_i = 1'b0;
    push_byte(8'h2A);
    run_frame("after_nreset", 1'b1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      rs = 1'($urandom_range(0, 1));
      if (rs) n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : 8;
      else    n = int'($urandom_range(0, 40));
      for (int i = 0; i < n; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
      coincide = (n > 0) && ($urandom_range(0, 4) == 0);
      run_frame($sformatf("rand%0d", t), rs, coincide);
    end

    check("pulse_width", 32'(long_pulses), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
